// File: rtl/neuron_mac_seq.sv
// Purpose: time-multiplexed fixed-point neuron pre-activation, sum(in[i]*w[i]) over enabled inputs plus bias.
// Latency: out_valid rises K+1 edges after the accept edge, K = ceil(N/LANES).
// Backpressure: one request in flight; in_ready stays low until the result is taken by out_ready.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; in_data (N x DATA_W), in_weight ((N+1) x DATA_W, element N = bias),
//                       in_enable (N, 0 masks the term)
//   out_valid/out_ready result handshake; out_data (saturated Q result), out_sat (result was clipped)
module neuron_mac_seq #(
  parameter int N      = 32,
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N*DATA_W-1:0]        in_data,
  input  logic [(N+1)*DATA_W-1:0]    in_weight,
  input  logic [N-1:0]               in_enable,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_sat
);

  localparam int K      = (N + LANES - 1) / LANES;
  localparam int PROD_W = 2 * DATA_W;
  // Wide enough for N+1 full-precision products, so the sum never wraps.
  localparam int ACC_W  = 2 * DATA_W + $clog2(N + 1) + 1;
  localparam int IDX_W  = $clog2(K * LANES + 1);
  localparam int SEL_W  = (N > 1) ? $clog2(N) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state_q, state_d;

  // Held low by reset and only set by the first clock after release, so in_ready
  // cannot be seen high while rst_n is asserted even though the state is IDLE.
  logic                     armed_q;
  logic signed [DATA_W-1:0] data_q   [N];
  logic signed [DATA_W-1:0] weight_q [N];
  logic [N-1:0]             enable_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [IDX_W-1:0]         idx_q;

  logic                     accept;
  logic                     last_cycle;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  res_shift;
  logic signed [ACC_W-1:0]  term [LANES];

  assign accept     = in_valid && in_ready;
  assign last_cycle = (idx_q + IDX_W'(LANES)) >= IDX_W'(N);
  assign bias_ext   = ACC_W'(signed'(in_weight[N*DATA_W +: DATA_W])) <<< FRAC;
  assign res_shift  = acc_q >>> FRAC;

  // One multiplier per lane; lanes past the last input (N not a multiple of
  // LANES) are forced to zero rather than reading a nonexistent element.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_W-1:0]         lane_idx;
    logic [SEL_W-1:0]         lane_sel;
    logic                     in_range;
    logic                     lane_on;
    logic signed [PROD_W-1:0] prod;

    assign lane_idx = idx_q + IDX_W'(l);
    assign in_range = lane_idx < IDX_W'(N);
    assign lane_sel = in_range ? SEL_W'(lane_idx) : '0;
    assign lane_on  = in_range && enable_q[lane_sel];
    assign prod     = PROD_W'(data_q[lane_sel]) * PROD_W'(weight_q[lane_sel]);
    assign term[l]  = lane_on ? {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} : '0;
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + term[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = armed_q;
        if (in_valid && armed_q) state_d = ACCUM;
      end
      ACCUM: begin
        if (last_cycle) state_d = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q   <= 1'b0;
      enable_q  <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        data_q[i]   <= '0;
        weight_q[i] <= '0;
      end
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < N; i++) begin
              data_q[i]   <= in_data[i*DATA_W +: DATA_W];
              weight_q[i] <= in_weight[i*DATA_W +: DATA_W];
            end
            enable_q <= in_enable;
            acc_q    <= bias_ext;
            idx_q    <= '0;
          end
        end
        ACCUM: begin
          acc_q <= acc_q + lane_sum;
          idx_q <= idx_q + IDX_W'(LANES);
        end
        DONE: begin
          // First DONE cycle: scale back to Q format (floor) and clip.
          if (!out_valid) begin
            out_valid <= 1'b1;
            if (res_shift > SAT_MAX) begin
              out_data <= SAT_MAX[DATA_W-1:0];
              out_sat  <= 1'b1;
            end else if (res_shift < SAT_MIN) begin
              out_data <= SAT_MIN[DATA_W-1:0];
              out_sat  <= 1'b1;
            end else begin
              out_data <= res_shift[DATA_W-1:0];
              out_sat  <= 1'b0;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
module tb_neuron_mac_seq;

  logic clk = 1'b0;
  logic rst_n;

  // Instance A: N=4, LANES=2 (K=2)
  logic               iv4, ir4, ov4, or4, os4;
  logic [63:0]        id4;
  logic [79:0]        iw4;
  logic [3:0]         ie4;
  logic signed [15:0] od4;

  // Instance B: N=5, LANES=2 (K=3, last cycle has an idle lane)
  logic               iv5, ir5, ov5, or5, os5;
  logic [79:0]        id5;
  logic [95:0]        iw5;
  logic [4:0]         ie5;
  logic signed [15:0] od5;

  neuron_mac_seq #(.N(4), .LANES(2), .DATA_W(16), .FRAC(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4), .in_data(id4), .in_weight(iw4), .in_enable(ie4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_sat(os4)
  );

  neuron_mac_seq #(.N(5), .LANES(2), .DATA_W(16), .FRAC(8)) u_dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv5), .in_ready(ir5), .in_data(id5), .in_weight(iw5), .in_enable(ie5),
    .out_valid(ov5), .out_ready(or5), .out_data(od5), .out_sat(os5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    string nm;
    int    d;
    int    s;
    int    acc;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [63:0] p4(input logic signed [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [79:0] p5(input logic signed [15:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  // Scoreboard monitors: compare on the first cycle each result is presented.
  bit   seen4 = 0, seen5 = 0;
  exp_t e4, e5;

  always @(negedge clk) begin
    if (!rst_n || !ov4) begin
      seen4 = 0;
    end else if (!seen4) begin
      seen4 = 1;
      if (q4.size() == 0) begin
        fail_now("dut4 unexpected result");
      end else begin
        e4 = q4.pop_front();
        check({e4.nm, " data"}, int'(od4), e4.d);
        check({e4.nm, " sat"}, int'(os4), e4.s);
        check({e4.nm, " latency"}, cyc - e4.acc, 3);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n || !ov5) begin
      seen5 = 0;
    end else if (!seen5) begin
      seen5 = 1;
      if (q5.size() == 0) begin
        fail_now("dut5 unexpected result");
      end else begin
        e5 = q5.pop_front();
        check({e5.nm, " data"}, int'(od5), e5.d);
        check({e5.nm, " sat"}, int'(os5), e5.s);
        check({e5.nm, " latency"}, cyc - e5.acc, 4);
      end
    end
  end

  task automatic send4(input string nm, input logic [63:0] d, input logic [79:0] w,
                       input logic [3:0] en, input int ed, input int es, input bit push);
    int n = 0;
    @(negedge clk);
    id4 = d; iw4 = w; ie4 = en; iv4 = 1'b1;
    while (!ir4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir4) begin
      fail_now({nm, " accept timeout"});
      iv4 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (push) q4.push_back('{nm, ed, es, cyc});
    // Scramble inputs after the accept edge; the result must not change.
    iv4 = 1'b0;
    id4 = {$urandom, $urandom};
    iw4 = {16'($urandom), $urandom, $urandom};
    ie4 = 4'($urandom);
  endtask

  task automatic send5(input string nm, input logic [79:0] d, input logic [95:0] w,
                       input logic [4:0] en, input int ed, input int es);
    int n = 0;
    @(negedge clk);
    id5 = d; iw5 = w; ie5 = en; iv5 = 1'b1;
    while (!ir5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ir5) begin
      fail_now({nm, " accept timeout"});
      iv5 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    q5.push_back('{nm, ed, es, cyc});
    iv5 = 1'b0;
    id5 = {16'($urandom), $urandom, $urandom};
    iw5 = {$urandom, $urandom, $urandom};
    ie5 = 5'($urandom);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [63:0] t1_d;
    logic [79:0] t1_w;

    rst_n = 1'b0;
    iv4 = 0; or4 = 1; id4 = '0; iw4 = '0; ie4 = '0;
    iv5 = 0; or5 = 1; id5 = '0; iw5 = '0; ie5 = '0;
    t1_d = p4(16'sd256, 16'sd512, -16'sd256, 16'sd128);
    t1_w = p5(16'sd128, 16'sd256, 16'sd512, 16'sd1024, 16'sd64);

    #12;
    check("reset in_ready", int'(ir4), 0);
    check("reset out_valid", int'(ov4), 0);
    check("reset out_data", int'(od4), 0);
    check("reset out_sat", int'(os4), 0);
    check("reset in_ready5", int'(ir5), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready after release", int'(ir4), 1);

    // Main function
    send4("t1 all enabled", t1_d, t1_w, 4'b1111, 704, 0, 1);
    send4("t2 enable 1101", t1_d, t1_w, 4'b1101, 192, 0, 1);
    send4("t2 enable 0", t1_d, t1_w, 4'b0000, 64, 0, 1);
    send4("t3 sat high", {4{16'sd32767}}, {5{16'sd32767}}, 4'b1111, 32767, 1, 1);
    send4("t3 sat low", {4{16'sh8000}}, {5{16'sd32767}}, 4'b1111, -32768, 1, 1);
    send4("floor neg", p4(-16'sd1, 16'sd0, 16'sd0, 16'sd0),
          p5(16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0), 4'b0001, -1, 0, 1);
    send4("bias max", t1_d, p5(16'sd5, 16'sd5, 16'sd5, 16'sd5, 16'sd32767), 4'b0000, 32767, 0, 1);
    send4("bias min", t1_d, p5(16'sd5, 16'sd5, 16'sd5, 16'sd5, 16'sh8000), 4'b0000, -32768, 0, 1);
    send4("just over max", p4(16'sd256, 16'sd0, 16'sd0, 16'sd0),
          p5(16'sd256, 16'sd0, 16'sd0, 16'sd0, 16'sd32767), 4'b0001, 32767, 1, 1);
    send4("just under min", p4(-16'sd1, 16'sd0, 16'sd0, 16'sd0),
          p5(16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sh8000), 4'b0001, -32768, 1, 1);

    // Partial last cycle on the N=5 instance
    send5("t5 all 1.0", {5{16'sd256}}, {16'sd0, {5{16'sd256}}}, 5'b11111, 1280, 0);
    send5("t5 last lane only", {16'sd512, {4{16'sd7}}}, {16'sd0, 16'sd256, {4{16'sd9}}},
          5'b10000, 512, 0);

    // Backpressure
    or4 = 1'b0;
    send4("t4 backpressure", t1_d, t1_w, 4'b1111, 704, 0, 1);
    n = 0;
    @(negedge clk);
    while (!ov4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ov4) fail_now("t4 out_valid timeout");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4 hold valid", int'(ov4), 1);
      check("t4 hold data", int'(od4), 704);
      check("t4 hold in_ready", int'(ir4), 0);
      iv4 = ~iv4;
      id4 = {$urandom, $urandom};
    end
    @(negedge clk);
    iv4 = 1'b0;
    or4 = 1'b1;
    @(negedge clk);
    check("t4 valid drop", int'(ov4), 0);
    check("t4 in_ready back", int'(ir4), 1);
    check("t4 data kept", int'(od4), 704);

    // Reset in the middle of accumulation
    send4("t6 aborted", t1_d, t1_w, 4'b1111, 704, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 reset out_valid", int'(ov4), 0);
    check("t6 reset in_ready", int'(ir4), 0);
    check("t6 reset out_data", int'(od4), 0);
    check("t6 reset out_sat", int'(os4), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6 in_ready after release", int'(ir4), 1);
    send4("t6 after reset", t1_d, t1_w, 4'b0000, 64, 0, 1);
    send4("t6 after reset full", t1_d, t1_w, 4'b1101, 192, 0, 1);

    n = 0;
    while ((q4.size() != 0 || q5.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain dut4", q4.size(), 0);
    check("drain dut5", q5.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
